// File: rtl/load_pulse_gen.sv
// Debounced pushbutton front end: synchronizes an active-low button, debounces
// press and release, and emits one registered Load pulse per accepted press.
module load_pulse_gen #(
   parameter int unsigned DB_COUNT = 500000
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Button_in,
   input  logic       Enable,
   output logic       Load,
   output logic       Button_level,
   output logic [7:0] Press_count
);

   localparam int unsigned   CW      = $clog2(DB_COUNT);
   localparam logic [CW-1:0] CNT_MAX = CW'(DB_COUNT - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   localparam logic [1:0] IDLE         = 2'd0;
   localparam logic [1:0] PRESS_WAIT   = 2'd1;
   localparam logic [1:0] PRESSED      = 2'd2;
   localparam logic [1:0] RELEASE_WAIT = 2'd3;

   logic          sync1_q, sync2_q;
   logic          sync_pressed;
   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          load_q, load_d;
   logic          level_q, level_d;
   logic [7:0]    count_q, count_d;

   assign sync_pressed = ~sync2_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (sync_pressed) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!sync_pressed) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_MAX) begin
               state_d = PRESSED;
               load_d  = Enable;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         PRESSED: begin
            if (!sync_pressed) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end
         end
         RELEASE_WAIT: begin
            // A return to pressed during release debounce is a bounce, not a new press.
            if (sync_pressed) begin
               state_d = PRESSED;
            end else if (cnt_q == CNT_MAX) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
   assign count_d = load_d ? count_q + 8'd1 : count_q;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         state_q <= IDLE;
         cnt_q   <= '0;
         load_q  <= 1'b0;
         level_q <= 1'b0;
         count_q <= '0;
      end else begin
         sync1_q <= Button_in;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         load_q  <= load_d;
         level_q <= level_d;
         count_q <= count_d;
      end
   end

   assign Load         = load_q;
   assign Button_level = level_q;
   assign Press_count  = count_q;

endmodule

// File: tb/tb_load_pulse_gen.sv
// Randomized bench for load_pulse_gen, checked each cycle against a run-length
// debounce model plus a few directed latency and count checks.
module tb_load_pulse_gen;

   localparam int unsigned DB = 4;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       Button_in = 1'b1;
   logic       Enable = 1'b1;
   logic       Load;
   logic       Button_level;
   logic [7:0] Press_count;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   load_pulse_gen #(.DB_COUNT(DB)) dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .Button_in    (Button_in),
      .Enable       (Enable),
      .Load         (Load),
      .Button_level (Button_level),
      .Press_count  (Press_count)
   );

   always #5 Clock = ~Clock;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
      end
   endtask

   // Reference: raw samples reach the debouncer two edges late; the debounced
   // level flips after DB+1 consecutive edges that disagree with it.
   bit          raw_q[$] = '{1'b1, 1'b1};
   bit          db_level = 1'b0;
   int unsigned run = 0;
   bit          exp_load = 1'b0;
   logic [7:0]  exp_count = '0;
   int unsigned edge_n = 0;
   int unsigned last_load_edge = 0;
   int unsigned load_pulses = 0;

   always @(posedge Clock) begin
      bit sp;
      edge_n++;
      exp_load = 1'b0;
      if (Reset) begin
         raw_q     = '{1'b1, 1'b1};
         db_level  = 1'b0;
         run       = 0;
         exp_count = '0;
      end else begin
         sp = !raw_q.pop_front();
         raw_q.push_back(Button_in);
         if (sp != db_level) begin
            run++;
            if (run == DB + 1) begin
               db_level = sp;
               run      = 0;
               if (sp && Enable) begin
                  exp_load  = 1'b1;
                  exp_count = exp_count + 8'd1;
               end
            end
         end else begin
            run = 0;
         end
      end
      #1;
      if (Load) begin
         last_load_edge = edge_n;
         load_pulses++;
      end
      check_eq("load",  32'(Load),         32'(exp_load));
      check_eq("level", 32'(Button_level), 32'(db_level));
      check_eq("count", 32'(Press_count),  32'(exp_count));
   end

   task automatic drive(input logic val, input int unsigned n);
      Button_in = val;
      repeat (n) @(negedge Clock);
   endtask

   initial begin
      int unsigned k;
      int unsigned pulses_before;

      repeat (20) @(negedge Clock);
      check_eq("reset_count", 32'(Press_count), 32'd0);
      Reset = 1'b0;
      drive(1'b1, 5);

      // Clean press: Load expected in the cycle after edge k+6.
      k = edge_n + 1;
      drive(1'b0, 20);
      check_eq("latency_edge", last_load_edge, k + DB + 2);
      check_eq("first_count", 32'(Press_count), 32'd1);
      check_eq("held_level", 32'(Button_level), 32'd1);
      drive(1'b1, 20);

      // Short glitch must be ignored.
      drive(1'b0, 2);
      drive(1'b1, 15);
      check_eq("glitch_count", 32'(Press_count), 32'd1);
      check_eq("glitch_level", 32'(Button_level), 32'd0);

      // Accepted press with release bounce: only one new pulse.
      pulses_before = load_pulses;
      drive(1'b0, 15);
      drive(1'b1, 2);
      drive(1'b0, 2);
      drive(1'b1, 15);
      check_eq("bounce_pulses", load_pulses - pulses_before, 32'd1);
      check_eq("bounce_level", 32'(Button_level), 32'd0);

      // Disabled press still tracks level but never loads.
      Enable = 1'b0;
      pulses_before = load_pulses;
      drive(1'b0, 15);
      check_eq("dis_level", 32'(Button_level), 32'd1);
      drive(1'b1, 15);
      check_eq("dis_pulses", load_pulses - pulses_before, 32'd0);
      check_eq("dis_count", 32'(Press_count), 32'd2);
      Enable = 1'b1;

      // Random bouncing with occasional Enable changes.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) == 0) Enable = ~Enable;
         drive(1'($urandom_range(0, 1)), $urandom_range(1, 9));
      end
      Enable = 1'b1;
      drive(1'b1, 15);

      // 256 clean presses from zero wrap the count.
      Reset = 1'b1;
      drive(1'b1, 2);
      Reset = 1'b0;
      pulses_before = load_pulses;
      for (int i = 0; i < 256; i++) begin
         drive(1'b0, $urandom_range(DB + 4, DB + 10));
         drive(1'b1, $urandom_range(DB + 4, DB + 10));
      end
      check_eq("wrap_pulses", load_pulses - pulses_before, 32'd256);
      check_eq("wrap_count", 32'(Press_count), 32'd0);

      // Button held across reset deassertion is re-debounced once.
      drive(1'b0, 12);
      Reset = 1'b1;
      drive(1'b0, 3);
      Reset = 1'b0;
      pulses_before = load_pulses;
      drive(1'b0, 20);
      check_eq("held_reset_pulses", load_pulses - pulses_before, 32'd1);
      drive(1'b1, 15);

      // Reset on the edge where the load would fire suppresses it.
      pulses_before = load_pulses;
      Button_in = 1'b0;
      repeat (5) @(negedge Clock);
      Reset = 1'b1;
      Button_in = 1'b1;
      repeat (2) @(negedge Clock);
      check_eq("midreset_pulses", load_pulses - pulses_before, 32'd0);
      check_eq("midreset_level", 32'(Button_level), 32'd0);
      check_eq("midreset_count", 32'(Press_count), 32'd0);
      Reset = 1'b0;
      drive(1'b1, 10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
